ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined CPU.
- Consumes the ID/EX operands and control, plus the ForwardA/ForwardB selects from the forwarding unit.
- Selects forwarded operands, performs the ALU operation and holds the EX/MEM pipeline register.
- Produces EMRd and EMRegw, which feed back into the forwarding unit, and the EX/MEM ALU result, which is the forwarding source.

Parameters:
WIDTH, 32, datapath width in bits
RW, 5, register index width

Ports:
clk  input  1  pipeline clock, rising edge active
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold EX/MEM register contents
flush  input  1  load a bubble into EX/MEM
IERsData  input  WIDTH  rs operand read in ID
IERtData  input  WIDTH  rt operand read in ID
IEImm  input  WIDTH  sign-extended immediate
IEShamt  input  5  shift amount
IEALUSrc  input  1  1: operand B = IEImm; 0: forwarded rt
IEALUCtrl  input  4  ALU operation select
IERd  input  RW  destination register
IERegw  input  1  register write enable
IEMemR  input  1  load
IEMemW  input  1  store
IEMemToReg  input  1  writeback selects memory data
ForwardA  input  2  operand A select
ForwardB  input  2  operand B select
MWData  input  WIDTH  MEM/WB writeback value
EMAluOut  output  WIDTH  registered ALU result
EMStoreData  output  WIDTH  registered forwarded rt value
EMRd  output  RW  registered destination
EMRegw  output  1  registered write enable
EMMemR  output  1  registered load flag
EMMemW  output  1  registered store flag
EMMemToReg  output  1  registered writeback select
EMZero  output  1  registered (ALU result == 0)

Behaviour:
- One clock, clk. Asynchronous active-low reset rst_n: while rst_n=0, every output is 0 immediately, without waiting for a clock edge.
- Forward select is combinational on the current inputs:
  - 0: ID/EX value.
  - 1: MWData.
  - 2: EMAluOut (current registered value).
  - 3: reserved, treated as 0.
- ForwardA applies to IERsData → fa; ForwardB applies to IERtData → fb.
- Operand B = IEALUSrc ? IEImm : fb. Store data = fb always (before the ALUSrc mux).
- ALU operations, all arithmetic modulo 2^WIDTH with no overflow trap:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A−B)
  - 0111 SLT, signed, result 1 or 0
  - 1000 SLL: B << IEShamt
  - 1001 SRL: B >> IEShamt
  - 1010 SRA: arithmetic B >> IEShamt
  - 1100 NOR
  - 1101 LUI: B << 16
  - any other code: result 0
- Latency: ALU result is visible on EMAluOut one cycle after inputs are presented.
- EX/MEM update priority per rising edge: reset > flush > stall > load.
  - flush=1: EMRegw, EMMemR, EMMemW and EMMemToReg cleared; EMRd=0; data fields cleared to 0.
  - stall=1, flush=0: every EX/MEM field holds its value.
  - flush=1 and stall=1 together: flush wins.
  - Otherwise all fields load from the current EX results and ID/EX control.
- EMRd is loaded as-is. EMRegw=1 with EMRd=0 is legal; the consumer ignores register 0.
- Forwarding from EMAluOut during a stall cycle returns the held value.
- Reset mid-operation: all in-flight EX/MEM state is discarded. The first post-reset edge loads normally.
- No internal state beyond the EX/MEM register; no X propagation on outputs after reset.

Test Plan:
- Reset: rst_n=0 with random inputs, no clock edge → all outputs 0 immediately. Release, load ADD 3+4 with Rd=5, Regw=1 → next edge EMAluOut=7, EMRd=5, EMRegw=1, EMZero=0.
- EX/MEM forward: cycle 1 ADD 10+20 → EMAluOut=30. Cycle 2 SUB with ForwardA=2, IERtData=5, IERsData=999 → EMAluOut=25.
- MEM/WB forward and ALUSrc:
  - ForwardB=1, MWData=0x0000_00F0, IEALUSrc=1, IEImm=0xF, AND, IERsData=0xFF → EMAluOut=0xF.
  - EMStoreData=0xF0 (forwarded rt, not the immediate).
- Arithmetic edges:
  - ADD 0xFFFF_FFFF+1 → 0, EMZero=1.
  - SLT −1 vs 1 → 1.
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - LUI imm 0x1234 → 0x1234_0000.
  - Code 1111 → 0.
- Stall/flush:
  - Load a result, then assert stall=1 for 3 cycles with changing inputs → outputs unchanged.
  - flush=1 together with stall=1 → EMRegw=0, EMMemW=0, EMRd=0 next edge.
- Reserved select and async reset: ForwardA=3 → operand A = IERsData. Pulse rst_n low for 2 ns between edges while EMRegw=1 → EMRegw drops immediately.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// EMAluOut is both the registered result and the EX/MEM forwarding source.
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] IERsData,
    input  logic [WIDTH-1:0] IERtData,
    input  logic [WIDTH-1:0] IEImm,
    input  logic [4:0]       IEShamt,
    input  logic             IEALUSrc,
    input  logic [3:0]       IEALUCtrl,
    input  logic [RW-1:0]    IERd,
    input  logic             IERegw,
    input  logic             IEMemR,
    input  logic             IEMemW,
    input  logic             IEMemToReg,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] MWData,
    output logic [WIDTH-1:0] EMAluOut,
    output logic [WIDTH-1:0] EMStoreData,
    output logic [RW-1:0]    EMRd,
    output logic             EMRegw,
    output logic             EMMemR,
    output logic             EMMemW,
    output logic             EMMemToReg,
    output logic             EMZero
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_NOR = 4'b1100,
        ALU_LUI = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_IDEX  = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;

    // Select 3 is reserved and falls back to the ID/EX value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fa = IERsData;
        case (ForwardA)
            FWD_MEMWB: fa = MWData;
            FWD_EXMEM: fa = EMAluOut;
            default:   fa = IERsData;
        endcase
    end

    always_comb begin
        fb = IERtData;
        case (ForwardB)
            FWD_MEMWB: fb = MWData;
            FWD_EXMEM: fb = EMAluOut;
            default:   fb = IERtData;
        endcase
    end

    assign op_b = IEALUSrc ? IEImm : fb;

    always_comb begin
        alu_res = '0;
        case (alu_op_e'(IEALUCtrl))
            ALU_AND: alu_res = fa & op_b;
            ALU_OR:  alu_res = fa | op_b;
            ALU_ADD: alu_res = fa + op_b;
            ALU_SUB: alu_res = fa - op_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(fa) < $signed(op_b))};
            ALU_SLL: alu_res = op_b << IEShamt;
            ALU_SRL: alu_res = op_b >> IEShamt;
            ALU_SRA: alu_res = $signed(op_b) >>> IEShamt;
            ALU_NOR: alu_res = ~(fa | op_b);
            ALU_LUI: alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

    // Priority: reset > flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all fields update together.
        if (!rst_n) begin
            EMAluOut    <= '0;
            EMStoreData <= '0;
            EMRd        <= '0;
            EMRegw      <= 1'b0;
            EMMemR      <= 1'b0;
            EMMemW      <= 1'b0;
            EMMemToReg  <= 1'b0;
            EMZero      <= 1'b0;
        end else if (flush) begin
            EMAluOut    <= '0;
            EMStoreData <= '0;
            EMRd        <= '0;
            EMRegw      <= 1'b0;
            EMMemR      <= 1'b0;
            EMMemW      <= 1'b0;
            EMMemToReg  <= 1'b0;
            EMZero      <= 1'b0;
        end else if (!stall) begin
            EMAluOut    <= alu_res;
            EMStoreData <= fb;
            EMRd        <= IERd;
            EMRegw      <= IERegw;
            EMMemR      <= IEMemR;
            EMMemW      <= IEMemW;
            EMMemToReg  <= IEMemToReg;
            EMZero      <= (alu_res == '0);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand sequences for
// forwarding/stall/flush/reset, then random stimulus against a behavioural model.
module tb_ex_stage;

    localparam int WIDTH = 32;
    localparam int RW    = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             stall, flush;
    logic [WIDTH-1:0] IERsData, IERtData, IEImm, MWData;
    logic [4:0]       IEShamt;
    logic             IEALUSrc;
    logic [3:0]       IEALUCtrl;
    logic [RW-1:0]    IERd;
    logic             IERegw, IEMemR, IEMemW, IEMemToReg;
    logic [1:0]       ForwardA, ForwardB;
    logic [WIDTH-1:0] EMAluOut, EMStoreData;
    logic [RW-1:0]    EMRd;
    logic             EMRegw, EMMemR, EMMemW, EMMemToReg, EMZero;

    ex_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .IERsData(IERsData), .IERtData(IERtData), .IEImm(IEImm), .IEShamt(IEShamt),
        .IEALUSrc(IEALUSrc), .IEALUCtrl(IEALUCtrl), .IERd(IERd), .IERegw(IERegw),
        .IEMemR(IEMemR), .IEMemW(IEMemW), .IEMemToReg(IEMemToReg),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MWData(MWData),
        .EMAluOut(EMAluOut), .EMStoreData(EMStoreData), .EMRd(EMRd), .EMRegw(EMRegw),
        .EMMemR(EMMemR), .EMMemW(EMMemW), .EMMemToReg(EMMemToReg), .EMZero(EMZero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the EX/MEM register contents.
    logic [31:0] m_alu, m_store;
    logic [4:0]  m_rd;
    logic        m_regw, m_memr, m_memw, m_m2r, m_zero;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_model(input string name);
        check({name, ".alu"},   EMAluOut,           m_alu);
        check({name, ".store"}, EMStoreData,        m_store);
        check({name, ".rd"},    32'(EMRd),          32'(m_rd));
        check({name, ".regw"},  32'(EMRegw),        32'(m_regw));
        check({name, ".memr"},  32'(EMMemR),        32'(m_memr));
        check({name, ".memw"},  32'(EMMemW),        32'(m_memw));
        check({name, ".m2r"},   32'(EMMemToReg),    32'(m_m2r));
        check({name, ".zero"},  32'(EMZero),        32'(m_zero));
    endtask

    task automatic model_clear();
        m_alu = 0; m_store = 0; m_rd = 0; m_regw = 0;
        m_memr = 0; m_memw = 0; m_m2r = 0; m_zero = 0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'(b);
        longint p2 = longint'(1) << sh;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'(longint'(a) + ub);
            4'd6:  return 32'(longint'(a) - ub);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return 32'(ub * p2);
            4'd9:  return 32'(ub / p2);
            4'd10: return b[31] ? ~((~b) / 32'(p2)) : 32'(ub / p2);
            4'd12: return ~(a | b);
            4'd13: return 32'(ub * 65536);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] raw);
        if (s == 2'd1) return MWData;
        if (s == 2'd2) return m_alu;
        return raw;
    endfunction

    // Applies one clock edge to both DUT and model, then compares all outputs.
    task automatic step(input string name);
        logic [31:0] a, fbv, b, r;
        a   = sel(ForwardA, IERsData);
        fbv = sel(ForwardB, IERtData);
        b   = IEALUSrc ? IEImm : fbv;
        r   = ref_alu(IEALUCtrl, a, b, IEShamt);
        @(posedge clk);
        if (rst_n) begin
            if (flush) model_clear();
            else if (!stall) begin
                m_alu = r; m_store = fbv; m_rd = IERd; m_regw = IERegw;
                m_memr = IEMemR; m_memw = IEMemW; m_m2r = IEMemToReg; m_zero = (r == 0);
            end
        end
        #1;
        check_model(name);
    endtask

    task automatic idle();
        stall = 0; flush = 0; IERsData = 0; IERtData = 0; IEImm = 0; IEShamt = 0;
        IEALUSrc = 0; IEALUCtrl = 4'd0; IERd = 0; IERegw = 0; IEMemR = 0; IEMemW = 0;
        IEMemToReg = 0; ForwardA = 0; ForwardB = 0; MWData = 0;
    endtask

    task automatic randomize_inputs();
        IERsData = $urandom; IERtData = $urandom; IEImm = $urandom; MWData = $urandom;
        IEShamt = 5'($urandom); IEALUSrc = 1'($urandom); IEALUCtrl = 4'($urandom);
        IERd = 5'($urandom); IERegw = 1'($urandom); IEMemR = 1'($urandom);
        IEMemW = 1'($urandom); IEMemToReg = 1'($urandom);
        ForwardA = 2'($urandom); ForwardB = 2'($urandom);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs, rt, imm, mw;
        logic        alusrc;
        logic [4:0]  shamt;
        logic [1:0]  fa, fb;
        logic [31:0] exp_alu, exp_store;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'b0000, 32'hFF, 32'h1234, 32'hF, 32'hF0, 1'b1, 5'd0, 2'd0, 2'd1, 32'hF, 32'hF0, 1'b0};
        vecs[1]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h1, 1'b1};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 2'd0, 32'h1, 32'h1, 1'b0};
        vecs[3]  = '{4'b1010, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 5'd4, 2'd0, 2'd0, 32'hF800_0000, 32'h8000_0000, 1'b0};
        vecs[4]  = '{4'b1101, 32'h0, 32'h55, 32'h1234, 32'h0, 1'b1, 5'd0, 2'd0, 2'd0, 32'h1234_0000, 32'h55, 1'b0};
        vecs[5]  = '{4'b1111, 32'h3, 32'h4, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 2'd0, 32'h0, 32'h4, 1'b1};
        vecs[6]  = '{4'b0110, 32'h7, 32'h2, 32'h0, 32'h99, 1'b0, 5'd0, 2'd3, 2'd0, 32'h5, 32'h2, 1'b0};
        vecs[7]  = '{4'b1000, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd31, 2'd0, 2'd0, 32'h8000_0000, 32'h1, 1'b0};
        vecs[8]  = '{4'b1001, 32'h0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 5'd31, 2'd0, 2'd0, 32'h1, 32'h8000_0000, 1'b0};
        vecs[9]  = '{4'b1100, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[10] = '{4'b0001, 32'hF0F0, 32'h0F0F, 32'h0, 32'h0, 1'b0, 5'd0, 2'd0, 2'd0, 32'hFFFF, 32'h0F0F, 1'b0};

        // Asynchronous reset with random inputs and no clock edge.
        randomize_inputs(); stall = 0; flush = 0;
        #1 rst_n = 0;
        #1 model_clear();
        check_model("reset_async");
        #1 rst_n = 1;

        idle();
        IERsData = 3; IERtData = 4; IEALUCtrl = 4'b0010; IERd = 5; IERegw = 1;
        step("first_add");
        check("first_add.const", EMAluOut, 32'd7);

        // EX/MEM forwarding into the following instruction.
        idle();
        IERsData = 10; IERtData = 20; IEALUCtrl = 4'b0010;
        step("fwd_add");
        IERsData = 999; IERtData = 5; ForwardA = 2; IEALUCtrl = 4'b0110;
        step("fwd_sub");
        check("fwd_sub.const", EMAluOut, 32'd25);

        foreach (vecs[i]) begin
            idle();
            IEALUCtrl = vecs[i].op; IERsData = vecs[i].rs; IERtData = vecs[i].rt;
            IEImm = vecs[i].imm; MWData = vecs[i].mw; IEALUSrc = vecs[i].alusrc;
            IEShamt = vecs[i].shamt; ForwardA = vecs[i].fa; ForwardB = vecs[i].fb;
            IERd = 5'(i); IERegw = 1;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.alu_const", i), EMAluOut, vecs[i].exp_alu);
            check($sformatf("vec%0d.store_const", i), EMStoreData, vecs[i].exp_store);
            check($sformatf("vec%0d.zero_const", i), 32'(EMZero), 32'(vecs[i].exp_zero));
        end

        // Stall holds for three cycles with changing inputs; forwarding sees held value.
        idle();
        IERsData = 100; IERtData = 23; IEALUCtrl = 4'b0010; IERd = 9; IERegw = 1; IEMemW = 1;
        step("pre_stall");
        for (int c = 0; c < 3; c++) begin
            randomize_inputs(); stall = 1; flush = 0;
            step($sformatf("stall%0d", c));
            check($sformatf("stall%0d.const", c), EMAluOut, 32'd123);
        end
        idle();
        ForwardA = 2; IERtData = 0; IEALUCtrl = 4'b0010;
        step("post_stall_fwd");
        check("post_stall_fwd.const", EMAluOut, 32'd123);

        // Flush together with stall clears the register.
        idle();
        IERsData = 1; IEALUCtrl = 4'b0010; IERd = 7; IERegw = 1; IEMemW = 1;
        step("pre_flush");
        randomize_inputs(); stall = 1; flush = 1;
        step("flush_stall");
        check("flush_stall.regw_const", 32'(EMRegw), 32'd0);
        check("flush_stall.rd_const", 32'(EMRd), 32'd0);

        // Short reset pulse between edges while EMRegw=1.
        idle();
        IERsData = 42; IEALUCtrl = 4'b0010; IERd = 3; IERegw = 1;
        step("pre_rst_pulse");
        #2 rst_n = 0;
        #1 model_clear();
        check_model("rst_pulse");
        check("rst_pulse.regw_const", 32'(EMRegw), 32'd0);
        #1 rst_n = 1;
        step("post_rst_load");

        // Random stimulus against the model.
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
